mmio_uart_io: RTL
=================

# mmio_uart_io

Memory-mapped UART and LED peripheral that attaches to the core's data-memory port alongside RAM, replacing the fixed I/O path of the single-cycle system. It adds programmable baud rate, parametrised TX/RX FIFOs, a status register with sticky error flags, and an RX-not-empty interrupt. The top level decodes the core's ALU address and store/load strobes into this block, and muxes `rdata` into the core's load path when `sel` is high.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_1000, block base; must be 16-byte aligned
- CLK_DIV, 434, reset baud divisor in clk cycles per bit (50 MHz / 115200)
- FIFO_DEPTH, 8, entries per FIFO; power of two, 2..256
- LED_W, 8, LED output width, 1..32

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-low reset
- addr  in  32  byte address from core ALU result
- wdata  in  32  store data
- we  in  1  store strobe
- re  in  1  load strobe; one pulse per executed load
- sel  out  1  combinational; `addr[31:4] == BASE_ADDR[31:4]`
- rdata  out  32  combinational read data; 0 when `sel` low
- rx  in  1  UART receive line, asynchronous
- tx  out  1  UART transmit line, idles high
- led_out  out  LED_W  LED register
- irq  out  1  high while RX FIFO is non-empty

## Operation
- Access is active only when `sel` is high. The register is selected by `addr[3:2]`. `addr[1:0]` and access size are ignored.
- Register map:
  - 0x0 DATA
    - Write: push `wdata[7:0]` to the TX FIFO. If the FIFO is full, the byte is dropped.
    - Read: `rdata[7:0]` is the RX FIFO head, or 0 if empty. `re` pops the head; `re` on an empty FIFO is ignored.
  - 0x4 STATUS (read)
    - bit0 tx_full, bit1 tx_empty, bit2 rx_avail, bit3 rx_full
    - bit4 rx_overrun (sticky), bit5 tx_busy (FSM not IDLE), bit6 frame_err (sticky)
    - [23:16] rx_count
  - 0x4 STATUS (write): writing 1 to bit4 or bit6 clears that flag. A set event in the same cycle wins over the clear.
  - 0x8 LED: read/write, `[LED_W-1:0]`.
  - 0xC DIV: read/write, [15:0]. Writes below 4 are stored as 4.
- FIFOs are circular, with pointers of log2(FIFO_DEPTH) bits plus a count. If push and pop occur in the same cycle while full or while empty-with-bypass-disallowed, both take effect when legal: a full FIFO with a simultaneous pop accepts the push.
- TX FSM: IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE.
  - In IDLE with the FIFO non-empty, the FSM pops and enters START.
  - Each state lasts DIV cycles. From STOP, if the FIFO is non-empty, the FSM goes directly to START (no idle gap).
- RX path: 2-flop synchroniser, then FSM IDLE -> START -> DATA -> STOP.
  - IDLE waits for a synchronised falling edge.
  - START re-samples at DIV/2. If high, it is a false start and the FSM returns to IDLE.
  - DATA samples at bit centres, every DIV cycles.
  - STOP samples at centre. If 0, frame_err is set and the byte is discarded. If 1, the byte is pushed; if the FIFO is full, the byte is dropped and rx_overrun is set.
  - The FSM returns to IDLE at the STOP sample point, not at the bit end.
- A DIV change takes effect at the next bit-counter reload. The bit currently in progress keeps the old period.

## Timing
- Reset (reset=0 at a clk edge):
  - tx=1, led_out=0, irq=0, DIV=CLK_DIV
  - FIFOs empty, sticky flags 0, both FSMs IDLE
  - Reset mid-frame aborts the frame immediately; tx=1 from the next edge.
- Register writes take effect at the clk edge where `we & sel` is high. A read of the same address in the next cycle returns the new value.
- The `re` pop occurs at the edge. `rdata` shows the new head in the following cycle.
- TX latency: a DATA write at edge N makes the FIFO non-empty. The FSM pops at edge N+1 and tx falls at edge N+1. One frame is exactly 10·DIV cycles.
- RX: the byte appears in the FIFO, and irq rises, 2 synchroniser cycles + DIV/2 + 9·DIV cycles after the rx falling edge (±1 cycle).
- `sel` and `rdata` have no registered delay; they are valid in the same cycle as `addr`.

## Test plan
- Reset: hold reset=0 for 2 cycles, then read STATUS -> 0x0000_0002 (tx_empty only); tx=1; DIV reads 434; led_out=0.
- TX: write DIV=4, then DATA=0xA5 -> tx: start bit, then bits 1,0,1,0,0,1,0,1, then stop bit, each exactly 4 cycles; tx_busy high for 40 cycles. Write 3 bytes back-to-back -> 120 contiguous frame cycles with no idle gap.
- RX loopback: DIV=4, tx tied to rx, send 0x3C -> irq high; STATUS rx_count=1; DATA reads 0x3C; `re` pulse -> irq=0.
- Overrun: DIV=4, inject FIFO_DEPTH+1 frames without pops -> rx_full=1, rx_overrun=1; pops return the first 8 bytes in order. Write STATUS bit4=1 -> overrun clears.
- Framing and false start: a frame with stop=0 -> frame_err=1, rx_count unchanged. A 1-cycle low glitch on rx -> no byte, FSM back to IDLE.
- TX full: with DIV=434, write 10 bytes quickly -> 1 byte in flight plus 8 queued accepted, 10th byte dropped; tx_full=1. Simultaneous push with FSM pop at full is accepted. Reset asserted mid-frame -> tx=1 and tx_empty=1 next cycle.

Source files
------------

// File: rtl/mmio_uart_io.sv
// mmio_uart_io: memory-mapped UART with TX/RX FIFOs, programmable baud divisor, sticky errors, LED register.
// Registers at addr[3:2]: 0 DATA, 1 STATUS, 2 LED, 3 DIV; rdata is zero whenever sel is low.
module mmio_uart_io #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int          CLK_DIV    = 434,
  parameter int          FIFO_DEPTH = 8,
  parameter int          LED_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic             we,
  input  logic             re,
  output logic             sel,
  output logic [31:0]      rdata,
  input  logic             rx,
  output logic             tx,
  output logic [LED_W-1:0] led_out,
  output logic             irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [1:0] S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3;

  logic [1:0]       w_reg;
  logic             w_wr, w_rd, w_unused;
  logic [15:0]      r_div;
  logic [LED_W-1:0] r_led;
  logic             r_ovr, r_ferr;
  logic [7:0]       r_txq [FIFO_DEPTH];
  logic [7:0]       r_rxq [FIFO_DEPTH];
  logic [AW-1:0]    r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
  logic [CW-1:0]    r_tx_cnt, r_rx_cnt;
  logic [1:0]       r_tx_st, r_rx_st;
  logic [15:0]      r_tx_tmr, r_rx_tmr;
  logic [2:0]       r_tx_bit, r_rx_bit;
  logic [7:0]       r_tx_sh, r_rx_sh, w_rx_head;
  logic             r_tx, r_rx_s1, r_rx_s2, r_rx_s3;
  logic             w_tx_full, w_tx_ne, w_tx_tick, w_tx_pop, w_tx_push;
  logic             w_rx_full, w_rx_ne, w_rx_tick, w_rx_stop, w_rx_in, w_rx_pop, w_rx_push, w_rx_ovf, w_ferr;
  logic [31:0]      w_status;

  assign sel      = addr[31:4] == BASE_ADDR[31:4];
  assign w_reg    = addr[3:2];
  assign w_wr     = we & sel;
  assign w_rd     = re & sel;
  assign w_unused = ^{addr[1:0], wdata};

  assign w_tx_full = r_tx_cnt == CW'(FIFO_DEPTH);
  assign w_tx_ne   = r_tx_cnt != '0;
  assign w_tx_tick = r_tx_tmr == '0;
  // The FSM pops from IDLE or at the end of STOP, giving back-to-back frames.
  assign w_tx_pop  = w_tx_ne & ((r_tx_st == S_IDLE) | ((r_tx_st == S_STOP) & w_tx_tick));
  assign w_tx_push = w_wr & (w_reg == 2'd0) & (!w_tx_full | w_tx_pop);

  assign w_rx_full = r_rx_cnt == CW'(FIFO_DEPTH);
  assign w_rx_ne   = r_rx_cnt != '0;
  assign w_rx_tick = r_rx_tmr == '0;
  assign w_rx_stop = (r_rx_st == S_STOP) & w_rx_tick;
  assign w_rx_in   = w_rx_stop & r_rx_s2;
  assign w_ferr    = w_rx_stop & !r_rx_s2;
  assign w_rx_pop  = w_rd & (w_reg == 2'd0) & w_rx_ne;
  assign w_rx_push = w_rx_in & (!w_rx_full | w_rx_pop);
  assign w_rx_ovf  = w_rx_in & w_rx_full & !w_rx_pop;

  always_ff @(posedge clk)
    if (!reset) begin
      r_div  <= 16'(CLK_DIV);
      r_led  <= '0;
      r_ovr  <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      if (w_wr & (w_reg == 2'd3)) r_div <= (wdata[15:0] < 16'd4) ? 16'd4 : wdata[15:0];
      if (w_wr & (w_reg == 2'd2)) r_led <= wdata[LED_W-1:0];
      r_ovr  <= w_rx_ovf | (r_ovr & !(w_wr & (w_reg == 2'd1) & wdata[4]));
      r_ferr <= w_ferr | (r_ferr & !(w_wr & (w_reg == 2'd1) & wdata[6]));
    end

  always_ff @(posedge clk) begin
    if (w_tx_push) r_txq[r_tx_wp] <= wdata[7:0];
    if (w_rx_push) r_rxq[r_rx_wp] <= r_rx_sh;
  end

  always_ff @(posedge clk)
    if (!reset) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
    end else begin
      r_tx_wp  <= r_tx_wp + AW'(w_tx_push);
      r_tx_rp  <= r_tx_rp + AW'(w_tx_pop);
      r_tx_cnt <= r_tx_cnt + CW'(w_tx_push) - CW'(w_tx_pop);
      r_rx_wp  <= r_rx_wp + AW'(w_rx_push);
      r_rx_rp  <= r_rx_rp + AW'(w_rx_pop);
      r_rx_cnt <= r_rx_cnt + CW'(w_rx_push) - CW'(w_rx_pop);
    end

  always_ff @(posedge clk)
    if (!reset) begin
      r_tx_st  <= S_IDLE;
      r_tx     <= 1'b1;
      r_tx_tmr <= '0;
      r_tx_bit <= '0;
      r_tx_sh  <= '0;
    end else if (w_tx_pop) begin
      r_tx_st  <= S_START;
      r_tx     <= 1'b0;
      r_tx_sh  <= r_txq[r_tx_rp];
      r_tx_tmr <= r_div - 16'd1;
    end else if (r_tx_st != S_IDLE) begin
      r_tx_tmr <= w_tx_tick ? r_div - 16'd1 : r_tx_tmr - 16'd1;
      if (w_tx_tick)
        case (r_tx_st)
          S_START: begin
            r_tx_st  <= S_DATA;
            r_tx     <= r_tx_sh[0];
            r_tx_bit <= '0;
          end
          S_DATA:
            if (r_tx_bit == 3'd7) begin
              r_tx_st <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_tx_sh  <= r_tx_sh >> 1;
              r_tx     <= r_tx_sh[1];
              r_tx_bit <= r_tx_bit + 3'd1;
            end
          default: begin
            r_tx_st <= S_IDLE;
            r_tx    <= 1'b1;
          end
        endcase
    end

  // r_rx_s3 is only the previous synchronised sample, used for falling-edge detection.
  always_ff @(posedge clk)
    if (!reset) begin
      r_rx_s1  <= 1'b1;
      r_rx_s2  <= 1'b1;
      r_rx_s3  <= 1'b1;
      r_rx_st  <= S_IDLE;
      r_rx_tmr <= '0;
      r_rx_bit <= '0;
      r_rx_sh  <= '0;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
      if (r_rx_st == S_IDLE) begin
        if (r_rx_s3 & !r_rx_s2) begin
          r_rx_st  <= S_START;
          r_rx_tmr <= (r_div >> 1) - 16'd1;
        end
      end else if (!w_rx_tick) r_rx_tmr <= r_rx_tmr - 16'd1;
      else begin
        r_rx_tmr <= r_div - 16'd1;
        case (r_rx_st)
          S_START: begin
            r_rx_st  <= r_rx_s2 ? S_IDLE : S_DATA;
            r_rx_bit <= '0;
          end
          S_DATA: begin
            r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
            r_rx_bit <= r_rx_bit + 3'd1;
            if (r_rx_bit == 3'd7) r_rx_st <= S_STOP;
          end
          default: r_rx_st <= S_IDLE;
        endcase
      end
    end

  assign w_rx_head = w_rx_ne ? r_rxq[r_rx_rp] : 8'h00;
  assign w_status  = {8'h00, 8'(r_rx_cnt), 9'h000, r_ferr, r_tx_st != S_IDLE, r_ovr,
                      w_rx_full, w_rx_ne, !w_tx_ne, w_tx_full};
  assign rdata     = !sel            ? 32'h0 :
                     (w_reg == 2'd0) ? {24'h0, w_rx_head} :
                     (w_reg == 2'd1) ? w_status :
                     (w_reg == 2'd2) ? 32'(r_led) : {16'h0, r_div};
  assign tx        = r_tx;
  assign led_out   = r_led;
  assign irq       = w_rx_ne;
endmodule
